// File: rtl/seg_scroll_ctrl.sv
// Scroll scheduler for a 4-digit seven-segment display: message buffer, prescaled
// step timing and a combinational frame decode. Optional macro SEG_SCROLL_REV_EN adds reverse scrolling.
`timescale 1ns/1ps
module seg_scroll_ctrl #(
  parameter int MSG_DEPTH = 16,
  parameter int ADDR_W    = 4,
  parameter int DIV_W     = 25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [6:0]        wr_data,
  output logic              wr_ready,
  input  logic [ADDR_W:0]   len,
  input  logic [DIV_W-1:0]  step_div,
  input  logic              loop_en,
  input  logic              start,
  input  logic              pause,
  input  logic              stop,
`ifdef SEG_SCROLL_REV_EN
  input  logic              rev,
`endif
  output logic              busy,
  output logic              done,
  output logic              step_tick,
  output logic [6:0]        HEX0,
  output logic [6:0]        HEX1,
  output logic [6:0]        HEX2,
  output logic [6:0]        HEX3
);

  localparam int POS_W = ADDR_W + 2;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(MSG_DEPTH);
  localparam logic [6:0] BLANK = 7'h7F;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  state_t            state, state_n;
  logic [POS_W-1:0]  pos, pos_n;
  logic [DIV_W-1:0]  cnt, cnt_n;
  logic [ADDR_W:0]   len_q, len_clamp;
  logic [DIV_W-1:0]  div_q, div_eff;
  logic              rev_q, rev_in;
  logic [6:0]        buf_mem [MSG_DEPTH];
  logic              accept, wr_ok, addr_ok, cnt_last, at_end;
  logic [POS_W-1:0]  last_q, last_new, wrap_pos, step_pos;
  logic [POS_W-1:0]  rd;
  logic [6:0]        hex [4];

`ifdef SEG_SCROLL_REV_EN
  assign rev_in = rev;
`else
  assign rev_in = 1'b0;
`endif

  // Write port: a write is taken on any clock edge where wr_en=1 and wr_ready=1
  // (IDLE/DONE); there is no back-pressure beyond dropping writes while busy.
  assign wr_ready = (state == S_IDLE) || (state == S_DONE);
  assign busy     = (state == S_RUN) || (state == S_PAUSE);

  generate
    if (MSG_DEPTH >= (1 << ADDR_W)) begin : g_addr_full
      assign addr_ok = 1'b1;
    end else begin : g_addr_part
      assign addr_ok = (wr_addr < ADDR_W'(MSG_DEPTH));
    end
  endgenerate

  assign wr_ok = wr_ready && wr_en && addr_ok;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      buf_mem[wr_addr] <= wr_data;
    end
  end

  assign len_clamp = (len > DEPTH_L) ? DEPTH_L : len;
  assign div_eff   = (step_div == '0) ? DIV_W'(1) : step_div;
  // stop outranks start even when idle
  assign accept    = wr_ready && start && !stop && (len != '0);
  assign last_q    = POS_W'(len_q) + POS_W'(3);
  assign last_new  = POS_W'(len_clamp) + POS_W'(3);
  assign cnt_last  = (cnt == div_q - DIV_W'(1));
  assign at_end    = rev_q ? (pos == '0) : (pos == last_q);
  assign wrap_pos  = rev_q ? last_q : '0;
  assign step_pos  = rev_q ? (pos - POS_W'(1)) : (pos + POS_W'(1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      pos   <= '0;
      cnt   <= '0;
      len_q <= '0;
      div_q <= DIV_W'(1);
      rev_q <= 1'b0;
    end else begin
      state <= state_n;
      pos   <= pos_n;
      cnt   <= cnt_n;
      if (accept) begin
        len_q <= len_clamp;
        div_q <= div_eff;
        rev_q <= rev_in;
      end
    end
  end

  always_comb begin
    state_n   = state;
    pos_n     = pos;
    cnt_n     = cnt;
    step_tick = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_n = S_RUN;
          pos_n   = rev_in ? last_new : '0;
          cnt_n   = '0;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_n = S_IDLE;
          pos_n   = '0;
          cnt_n   = '0;
        end else if (pause) begin
          state_n = S_PAUSE;
        end else if (cnt_last) begin
          step_tick = 1'b1;
          cnt_n     = '0;
          if (!at_end) begin
            pos_n = step_pos;
          end else if (loop_en) begin
            pos_n = wrap_pos;
          end else begin
            state_n = S_DONE;
            done    = 1'b1;
            pos_n   = '0;
          end
        end else begin
          cnt_n = cnt + DIV_W'(1);
        end
      end
      S_PAUSE: begin
        if (stop) begin
          state_n = S_IDLE;
          pos_n   = '0;
          cnt_n   = '0;
        end else if (!pause) begin
          state_n = S_RUN;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Digit k shows message entry pos-1-k when 1 <= pos-k <= L; all blank outside RUN/PAUSE.
  always_comb begin
    rd = '0;
    for (int k = 0; k < 4; k++) begin
      hex[k] = BLANK;
      if (busy && (pos > POS_W'(k))) begin
        rd = pos - POS_W'(k + 1);
        if (rd < POS_W'(len_q)) begin
          hex[k] = buf_mem[rd[ADDR_W-1:0]];
        end
      end
    end
  end

  assign HEX0 = hex[0];
  assign HEX1 = hex[1];
  assign HEX2 = hex[2];
  assign HEX3 = hex[3];

endmodule

// File: tb/tb_seg_scroll_ctrl.sv
// Self-checking bench for seg_scroll_ctrl: scenario tasks plus a frame scoreboard
// that pops an expected display frame on every step_tick.
`timescale 1ns/1ps
module tb_seg_scroll_ctrl;
  localparam int MSG_DEPTH = 16;
  localparam int ADDR_W    = 4;
  localparam int DIV_W     = 25;
  localparam logic [6:0] B  = 7'h7F;
  localparam logic [6:0] SP = 7'h0C;
  localparam logic [6:0] SL = 7'h47;
  localparam logic [6:0] SU = 7'h41;
  localparam logic [6:0] SS = 7'h12;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [6:0]        wr_data = '0;
  logic              wr_ready;
  logic [ADDR_W:0]   len = '0;
  logic [DIV_W-1:0]  step_div = '0;
  logic              loop_en = 1'b0;
  logic              start = 1'b0;
  logic              pause = 1'b0;
  logic              stop = 1'b0;
`ifdef SEG_SCROLL_REV_EN
  logic              rev = 1'b0;
`endif
  logic              busy, done, step_tick;
  logic [6:0]        hex0, hex1, hex2, hex3;

  seg_scroll_ctrl #(.MSG_DEPTH(MSG_DEPTH), .ADDR_W(ADDR_W), .DIV_W(DIV_W)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .len(len), .step_div(step_div), .loop_en(loop_en),
    .start(start), .pause(pause), .stop(stop),
`ifdef SEG_SCROLL_REV_EN
    .rev(rev),
`endif
    .busy(busy), .done(done), .step_tick(step_tick),
    .HEX0(hex0), .HEX1(hex1), .HEX2(hex2), .HEX3(hex3)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [27:0] exp_q[$];
  logic [6:0]  tb_buf [MSG_DEPTH];
  bit          mon_en = 1'b0;
  int          mon_period = 0;
  int          mon_last = 0;
  int          done_cnt = 0;
  logic [27:0] mon_exp;
  logic [27:0] frame_obs;

  assign frame_obs = {hex3, hex2, hex1, hex0};

  always @(posedge clk) cyc++;

  // scoreboard: each step shows the frame of the position being left
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (mon_en && step_tick) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_extra_step: got frame %h, none expected (cyc %0d)", frame_obs, cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        if (frame_obs !== mon_exp) begin
          bad++;
          $display("FAIL sb_frame: got %h expected %h (cyc %0d)", frame_obs, mon_exp, cyc);
        end
      end
      if (mon_period != 0) begin
        total++;
        if (cyc - mon_last != mon_period) begin
          bad++;
          $display("FAIL sb_step_period: got %0d expected %0d", cyc - mon_last, mon_period);
        end
      end
      mon_last = cyc;
    end
  end

  function automatic logic [27:0] exp_frame(int p, int l);
    logic [27:0] f;
    f = {4{B}};
    for (int k = 0; k < 4; k++) begin
      if ((p - k >= 1) && (p - k <= l)) f[k*7 +: 7] = tb_buf[p-1-k];
    end
    return f;
  endfunction

  function automatic logic [27:0] plus_frame(int p);
    case (p)
      0: return {B, B, B, B};
      1: return {B, B, B, SP};
      2: return {B, B, SP, SL};
      3: return {B, SP, SL, SU};
      4: return {SP, SL, SU, SS};
      5: return {SL, SU, SS, B};
      6: return {SU, SS, B, B};
      default: return {SS, B, B, B};
    endcase
  endfunction

  // driver tasks
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write_word(input logic [ADDR_W-1:0] a, input logic [6:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic write_plus();
    write_word(0, SP); write_word(1, SL); write_word(2, SU); write_word(3, SS);
    tb_buf[0] = SP; tb_buf[1] = SL; tb_buf[2] = SU; tb_buf[3] = SS;
  endtask

  task automatic start_run(input logic [ADDR_W:0] l, input logic [DIV_W-1:0] d, input logic lp);
    len = l; step_div = d; loop_en = lp; start = 1'b1;
    mon_last = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_not_busy(input int budget);
    for (int i = 0; i < budget && busy; i++) tick();
  endtask

  task automatic wait_q_size(input int sz, input int budget);
    for (int i = 0; i < budget && exp_q.size() != sz; i++) tick();
  endtask

  task automatic do_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b0;
    wait_cycles(2);
    reset = 1'b1;
    total++; if (frame_obs !== {4{B}}) begin bad++; $display("FAIL reset_hex: got %h expected %h", frame_obs, {4{B}}); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    total++; if (done !== 1'b0 || step_tick !== 1'b0) begin bad++; $display("FAIL reset_pulses: got done=%b tick=%b expected 0 0", done, step_tick); end
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready: got %b expected 1", wr_ready); end
  endtask

  task automatic test_plus_once();
    write_plus();
    exp_q.delete(); done_cnt = 0; mon_en = 1'b1; mon_period = 3;
    for (int p = 0; p < 8; p++) exp_q.push_back(plus_frame(p));
    start_run(5'd4, 25'd3, 1'b0);
    wait_not_busy(60);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL once_timeout: busy=%b expected 0", busy); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL once_frames_left: got %0d expected 0", exp_q.size()); end
    total++; if (frame_obs !== {4{B}} || wr_ready !== 1'b1) begin bad++; $display("FAIL once_done_state: hex=%h wr_ready=%b expected blank 1", frame_obs, wr_ready); end
    wait_cycles(5);
    total++; if (done_cnt != 1) begin bad++; $display("FAIL once_done_pulses: got %0d expected 1", done_cnt); end
    mon_en = 1'b0;
  endtask

  task automatic test_loop();
    exp_q.delete(); done_cnt = 0; mon_en = 1'b1; mon_period = 3;
    for (int p = 0; p < 8; p++) exp_q.push_back(plus_frame(p));
    exp_q.push_back({4{B}});
    exp_q.push_back(plus_frame(1));
    start_run(5'd4, 25'd3, 1'b1);
    wait_q_size(0, 80);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL loop_timeout: frames left %0d expected 0", exp_q.size()); end
    total++; if (busy !== 1'b1 || done_cnt != 0) begin bad++; $display("FAIL loop_busy: busy=%b done_cnt=%0d expected 1 0", busy, done_cnt); end
    do_stop();
    total++; if (busy !== 1'b0 || frame_obs !== {4{B}}) begin bad++; $display("FAIL loop_stop: busy=%b hex=%h expected 0 blank", busy, frame_obs); end
    mon_en = 1'b0;
  endtask

  task automatic test_pause();
    int lat;
    exp_q.delete(); mon_en = 1'b1; mon_period = 0;
    for (int p = 0; p < 3; p++) exp_q.push_back(plus_frame(p));
    start_run(5'd4, 25'd4, 1'b1);
    wait_q_size(1, 40);
    wait_cycles(2);
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (step_tick !== 1'b0 || frame_obs !== plus_frame(2) || busy !== 1'b1) begin
        bad++;
        $display("FAIL pause_hold: tick=%b hex=%h busy=%b expected 0 %h 1", step_tick, frame_obs, busy, plus_frame(2));
      end
    end
    pause = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (step_tick) begin lat = k; break; end
    end
    total++; if (lat != 3) begin bad++; $display("FAIL pause_resume_latency: got %0d expected 3", lat); end
    do_stop();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL pause_frames_left: got %0d expected 0", exp_q.size()); end
    mon_en = 1'b0;
  endtask

  task automatic test_fast();
    logic [6:0] code;
    code = 7'($urandom_range(0, 126));
    write_word(0, code);
    tb_buf[0] = code;
    exp_q.delete(); done_cnt = 0; mon_en = 1'b1; mon_period = 1;
    for (int p = 0; p < 5; p++) exp_q.push_back(exp_frame(p, 1));
    start_run(5'd1, 25'd0, 1'b0);
    wait_not_busy(20);
    total++; if (exp_q.size() != 0 || busy !== 1'b0) begin bad++; $display("FAIL fast_frames: left=%0d busy=%b expected 0 0", exp_q.size(), busy); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL fast_done: got %0d expected 1", done_cnt); end
    mon_en = 1'b0;
  endtask

  task automatic test_len_zero();
    bit seen;
    seen = 1'b0;
    start_run(5'd0, 25'd3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (busy || step_tick) seen = 1'b1;
      tick();
    end
    total++; if (seen !== 1'b0 || wr_ready !== 1'b1) begin bad++; $display("FAIL len_zero: active=%b wr_ready=%b expected 0 1", seen, wr_ready); end
  endtask

  task automatic test_len_clamp();
    logic [6:0] code;
    for (int a = 0; a < MSG_DEPTH; a++) begin
      code = 7'($urandom_range(0, 127));
      write_word(ADDR_W'(a), code);
      tb_buf[a] = code;
    end
    exp_q.delete(); done_cnt = 0; mon_en = 1'b1; mon_period = 1;
    for (int p = 0; p < 20; p++) exp_q.push_back(exp_frame(p, 16));
    start_run(5'd20, 25'd1, 1'b0);
    wait_not_busy(100);
    total++; if (exp_q.size() != 0 || busy !== 1'b0) begin bad++; $display("FAIL clamp_frames: left=%0d busy=%b expected 0 0", exp_q.size(), busy); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL clamp_done: got %0d expected 1", done_cnt); end
    mon_en = 1'b0;
  endtask

  task automatic test_stop_start();
    write_plus();
    start_run(5'd4, 25'd2, 1'b1);
    wait_cycles(5);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL stop_start_run: busy=%b expected 1", busy); end
    stop = 1'b1; start = 1'b1;
    tick();
    total++; if (busy !== 1'b0 || frame_obs !== {4{B}} || wr_ready !== 1'b1) begin bad++; $display("FAIL stop_start_idle: busy=%b hex=%h wr_ready=%b expected 0 blank 1", busy, frame_obs, wr_ready); end
    stop = 1'b0; start = 1'b0;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL stop_start_stay: busy=%b expected 0", busy); end
  endtask

  task automatic test_busy_write();
    start_run(5'd4, 25'd2, 1'b1);
    wait_cycles(3);
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL busy_wr_ready: got %b expected 0", wr_ready); end
    write_word(0, 7'h00);
    write_word(1, 7'h00);
    do_stop();
    exp_q.delete(); mon_en = 1'b1; mon_period = 2;
    for (int p = 0; p < 8; p++) exp_q.push_back(plus_frame(p));
    start_run(5'd4, 25'd2, 1'b0);
    wait_not_busy(40);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL busy_write_frames: left=%0d expected 0", exp_q.size()); end
    mon_en = 1'b0;
  endtask

  task automatic test_write_with_start();
    logic [6:0] code;
    code = 7'($urandom_range(0, 126));
    tb_buf[0] = code;
    exp_q.delete(); mon_en = 1'b1; mon_period = 2;
    for (int p = 0; p < 5; p++) exp_q.push_back(exp_frame(p, 1));
    wr_en = 1'b1; wr_addr = '0; wr_data = code;
    start_run(5'd1, 25'd2, 1'b0);
    wr_en = 1'b0;
    wait_not_busy(40);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL write_start_frames: left=%0d expected 0", exp_q.size()); end
    mon_en = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    write_plus();
    start_run(5'd4, 25'd3, 1'b1);
    wait_cycles(7);
    total++; if (busy !== 1'b1 || frame_obs === {4{B}}) begin bad++; $display("FAIL rst_mid_pre: busy=%b hex=%h expected 1 non-blank", busy, frame_obs); end
    reset = 1'b0;
    tick();
    total++; if (busy !== 1'b0 || frame_obs !== {4{B}} || wr_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_hold: busy=%b hex=%h wr_ready=%b expected 0 blank 1", busy, frame_obs, wr_ready); end
    tick();
    reset = 1'b1;
    tick();
    total++; if (busy !== 1'b0 || frame_obs !== {4{B}} || step_tick !== 1'b0) begin bad++; $display("FAIL rst_mid_after: busy=%b hex=%h tick=%b expected 0 blank 0", busy, frame_obs, step_tick); end
  endtask

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_plus_once();
    test_loop();
    test_pause();
    test_fast();
    test_len_zero();
    test_len_clamp();
    test_stop_start();
    test_busy_write();
    test_write_with_start();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
